// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 640x480@60 Hz display path.
// Also exports the packed sync bundle carried through the delay line.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The font/image ROM map starts right after the frame buffer.
  localparam int SCREEN_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
  } sync_t;

  // Idle strobes: both syncs high, blanked.
  localparam sync_t SYNC_IDLE = '{
    hsync_n: 1'b1,
    vsync_n: 1'b1,
    blank_n: 1'b0
  };

endpackage

// File: rtl/sync_delay.sv
// DEPTH-stage, 3-bit tick-enabled shift register with async reset load.
// Ports: clock, resetn, tick (enable), d (in), q (DEPTH ticks later).
module sync_delay #(
  parameter int         DEPTH = 2,
  parameter logic [2:0] INIT  = 3'b110
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic [2:0] d,
  output logic [2:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_pipe
      logic [2:0] stage [DEPTH];

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++)
            stage[i] <= INIT;
        end else if (tick) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++)
            stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_timing.sv
// Raster counter, pixel address and pipeline-aligned sync/blank strobes.
// Ports: clock, resetn, pixTick in; curAddress/curX/curY/videoOn/syncs/frameStart out.
module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        pixTick,
  output logic [18:0] curAddress,
  output logic [9:0]  curX,
  output logic [9:0]  curY,
  output logic        videoOn,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        frameStart
);

  localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_LEN - 1);
  localparam logic [9:0] V_LAST = 10'(V_LEN - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic [18:0] addr_count;
  logic        h_wrap;
  logic        v_wrap;
  logic        video_on;
  sync_t       raw;
  sync_t       raw_next;
  sync_t       dly;
  logic        frame_start;

  assign h_wrap   = (h_count == H_LAST);
  assign v_wrap   = (v_count == V_LAST);
  assign video_on = (h_count < H_ACT) && (v_count < V_ACT);

  always_comb begin
    h_next = h_count + 10'd1;
    v_next = v_count;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : v_count + 10'd1;
    end
  end

  // Strobes are decoded from the next count and registered, so the
  // register output lines up with the count it describes.
  always_comb begin
    raw_next.hsync_n = !((h_next >= HS_ON) && (h_next < HS_OFF));
    raw_next.vsync_n = !((v_next >= VS_ON) && (v_next < VS_OFF));
    raw_next.blank_n = (h_next < H_ACT) && (v_next < V_ACT);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_count     <= '0;
      v_count     <= '0;
      addr_count  <= '0;
      raw         <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pixTick && h_wrap && v_wrap;
      if (pixTick) begin
        h_count <= h_next;
        v_count <= v_next;
        raw     <= raw_next;
        // Holds through blanking so it already names the next pixel.
        if (video_on)
          addr_count <= (addr_count == ADDR_LAST) ? '0
                      : addr_count + 19'd1;
      end
    end
  end

  sync_delay #(
    .DEPTH (PIPE_DEPTH),
    .INIT  (SYNC_IDLE)
  ) u_sync_delay (
    .clock  (clock),
    .resetn (resetn),
    .tick   (pixTick),
    .d      (raw),
    .q      (dly)
  );

  assign curAddress = addr_count;
  assign curX       = h_count;
  assign curY       = v_count;
  assign videoOn    = video_on;
  assign hsync_n    = dly.hsync_n;
  assign vsync_n    = dly.vsync_n;
  assign blank_n    = dly.blank_n;
  assign frameStart = frame_start;

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Raster timing generator for the 640x480@60 Hz display path. It produces the pixel address that drives the screen-content processors and the image-ROM lookup. It also produces the hsync/vsync/blank strobes, delayed so they stay aligned with the colour index leaving the ROM and palette pipeline. It sits directly upstream of the high-score and game-screen processors and feeds their `curAddress` input.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch, sync and back porch in pixel ticks
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch, sync and back porch in lines
- `PIPE_DEPTH`, 2, pixel ticks between `curAddress` and a valid colour index at the DAC (ROM + palette); legal range 0..7

Ports:
- `clock` in 1: system clock, 50 MHz
- `resetn` in 1: reset, asynchronous, active-low
- `pixTick` in 1: pixel-clock enable; one pulse every second `clock` gives 25 MHz
- `curAddress` out 19: linear pixel address y*640+x of the pixel being fetched
- `curX` out 10: current horizontal count, 0..799
- `curY` out 10: current vertical count, 0..524
- `videoOn` out 1: current count lies in the active region (undelayed)
- `hsync_n` out 1: horizontal sync, active-low, delayed `PIPE_DEPTH` ticks
- `vsync_n` out 1: vertical sync, active-low, delayed `PIPE_DEPTH` ticks
- `blank_n` out 1: delayed `videoOn`
- `frameStart` out 1: one-`clock` pulse on the tick that enters (0,0)

## Operation
- **Counters.**
  - `hCount` runs 0..H_TOTAL-1 with H_TOTAL = 800. `vCount` runs 0..V_TOTAL-1 with V_TOTAL = 525.
  - Counters advance only on `clock` edges where `pixTick` = 1.
  - `hCount` wraps 799->0 and on that same tick increments `vCount`. `vCount` wraps 524->0.
- **Active region.** `videoOn` = (hCount < 640) && (vCount < 480). `curX` = hCount, `curY` = vCount.
- **Address counter.** `addrCount` is 19 bits and uses no multiplier.
  - It increments by 1 on every tick where `videoOn` = 1.
  - When it would pass 307199 it is set to 0.
  - During blanking it holds, so it already points at the next visible pixel.
  - `curAddress` = `addrCount`.
- **Raw sync signals.**
  - hsync is asserted when 656 <= hCount < 752.
  - vsync is asserted when 490 <= vCount < 492.
  - Both are polarity-inverted, i.e. active-low.
- **Sync delay.** Raw hsync_n, vsync_n and videoOn enter a `PIPE_DEPTH`-stage shift register clocked by `pixTick`. With `PIPE_DEPTH` = 0 they pass straight through from registers.
- **Frame pulse.** `frameStart` is registered, high for exactly one `clock` after the tick that makes hCount = vCount = 0.
- **Tick rate.** Back-to-back `pixTick` (every `clock`) is legal and simply runs the raster at 50 MHz. No other behaviour changes.

## Timing
- All outputs except `videoOn` are registered.
- `videoOn`, `curX`, `curY` and `curAddress` update on the same edge as the counters.
- **Reset values.**
  - hCount = vCount = 0, addrCount = 0.
  - hsync_n = vsync_n = 1, blank_n = 0, frameStart = 0.
  - All shift-register stages are loaded with inactive values: sync high, blank_n low.
- **First tick after reset.** The first tick after `resetn` deasserts moves the count to (1,0). `frameStart` is not pulsed for the reset-entered frame.
- **Alignment.** The `blank_n`/sync edge for pixel (x,y) appears exactly `PIPE_DEPTH` ticks after `curAddress` presents that pixel.
- **Mid-frame reset.** Asserting `resetn` low mid-frame clears all state immediately and asynchronously. No partial sync pulse is extended.
- **Rates.** Line period is 800 ticks. Frame period is 420000 ticks (16.8 ms at 25 MHz).

## Structure
- **Shared package `vga_pkg`.**
  - Holds the timing constants (H_*, V_*, H_TOTAL, V_TOTAL).
  - Holds SCREEN_PIXELS = 307200, which the font/image ROM address map also uses as its base offset.
- **Sub-module `sync_delay`.** A parameterised N-deep, 3-bit-wide shift register with tick enable and asynchronous-reset load value. The palette stage reuses it.

## Test plan
- **Reset check.** Hold `resetn` low, pulse `pixTick` -> counters stay 0, `hsync_n` = `vsync_n` = 1, `blank_n` = 0. Release it -> the next tick gives `curX` = 1.
- **Line 0 addresses.** Tick 639 times -> `curAddress` = 639. Tick 161 more -> `curY` = 1, `curAddress` = 640 (the address held through blanking).
- **Horizontal sync.** `PIPE_DEPTH` = 2, line 0 -> `hsync_n` falls 2 ticks after hCount reaches 656 and rises 2 ticks after hCount reaches 752. Low width is 96 ticks.
- **Vertical sync and wrap.** vsync_n is low for exactly 1600 ticks starting at line 490 (+2-tick delay). At (799,524) the next tick gives (0,0), `curAddress` = 0 and a single-`clock` `frameStart`.
- **Tick gaps.** Random gaps in `pixTick` -> counters hold, `frameStart` fires once per frame, frame period is 420000 ticks.
- **Mid-frame reset.** Assert `resetn` at (300,200) -> all outputs hold their reset values within the same `clock`. After release the raster restarts from (0,0), `curAddress` = 0.
